// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV64I-subset control sequencer.
package rv_ctrl_pkg;

  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned ALUOP_W  = 2;

  localparam logic [OPCODE_W-1:0] OP_R    = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_LD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_ADDI = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_SD   = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_B    = 7'b1100011;

  localparam logic [ALUOP_W-1:0] ALU_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALU_SUB   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5
  } state_e;

  // Datapath control lines driven by the sequencer each cycle.
  typedef struct packed {
    logic               imem_read;
    logic               ir_write;
    logic               pc_write;
    logic               pc_src;
    logic [ALUOP_W-1:0] alu_op;
    logic               alu_src;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               reg_write;
  } ctrl_t;

  // True for the opcodes the datapath can execute.
  function automatic logic is_legal_op(input logic [OPCODE_W-1:0] op);
    return (op == OP_R) || (op == OP_LD) || (op == OP_ADDI) ||
           (op == OP_SD) || (op == OP_B);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Counts ready-low wait cycles; flags the WAIT_MAX-th consecutive low cycle.
module mc_wait_timer #(
  parameter int unsigned WAIT_MAX = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_c_o
);

  localparam int unsigned       CNT_W = $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WAIT_MAX - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear has priority so every state entry restarts the count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Wait-count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // This low-ready cycle is the WAIT_MAX-th one in a row.
  assign expired_c_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV64I-subset datapath.
module multicycle_ctrl_fsm
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_MAX    = 16,
  parameter int unsigned INSTR_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [OPCODE_W-1:0]    ir_opcode,
  input  logic                   imem_ready,
  input  logic                   dmem_ready,
  input  logic                   alu_zero,
  output logic                   imem_read,
  output logic                   ir_write,
  output logic                   pc_write,
  output logic                   pc_src,
  output logic [ALUOP_W-1:0]     ALUOp,
  output logic                   ALUSrc,
  output logic                   memRead,
  output logic                   memWrite,
  output logic                   memtoReg,
  output logic                   regWrite,
  output logic                   instr_done,
  output logic                   illegal_op,
  output logic                   mem_timeout,
  output logic [INSTR_CNT_W-1:0] instr_count
);

  state_e                 state_q, state_d;
  logic [OPCODE_W-1:0]    op_q, op_d;
  logic                   illegal_q, illegal_d;
  logic                   timeout_q, timeout_d;
  logic [INSTR_CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t                  ctrl_c;
  logic                   retire_c;
  logic                   wait_en_c;
  logic                   wait_clr_c;
  logic                   expired_c;

  // Waiting means sitting in a memory state with its ready low; anything else restarts the count.
  assign wait_en_c  = ((state_q == ST_FETCH) && !imem_ready) ||
                      ((state_q == ST_MEM)   && !dmem_ready);
  assign wait_clr_c = !wait_en_c || expired_c;

  mc_wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (wait_clr_c),
    .en_i        (wait_en_c),
    .expired_c_o (expired_c)
  );

  // State, latched opcode, sticky flags and retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state and control decode from state plus the opcode latched in DECODE.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    ctrl_c    = '0;
    retire_c  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end

      ST_FETCH: begin
        ctrl_c.imem_read = 1'b1;
        if (imem_ready) begin
          ctrl_c.ir_write = 1'b1;
          ctrl_c.pc_write = 1'b1;
          state_d         = ST_DECODE;
        end else if (expired_c) begin
          timeout_d = 1'b1;
          state_d   = ST_FETCH;
        end
      end

      ST_DECODE: begin
        op_d = ir_opcode;
        if (is_legal_op(ir_opcode)) begin
          state_d = ST_EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = ST_FETCH;
        end
      end

      ST_EXEC: begin
        if (op_q == OP_R) begin
          ctrl_c.alu_op = ALU_FUNCT;
          state_d       = ST_WB;
        end else if (op_q == OP_ADDI) begin
          ctrl_c.alu_op  = ALU_ADD;
          ctrl_c.alu_src = 1'b1;
          state_d        = ST_WB;
        end else if ((op_q == OP_LD) || (op_q == OP_SD)) begin
          ctrl_c.alu_op  = ALU_ADD;
          ctrl_c.alu_src = 1'b1;
          state_d        = ST_MEM;
        end else if (op_q == OP_B) begin
          ctrl_c.alu_op   = ALU_SUB;
          ctrl_c.pc_write = alu_zero;
          ctrl_c.pc_src   = 1'b1;
          retire_c        = 1'b1;
          state_d         = ST_FETCH;
        end else begin
          state_d = ST_FETCH;
        end
      end

      ST_MEM: begin
        ctrl_c.mem_read  = (op_q == OP_LD);
        ctrl_c.mem_write = (op_q == OP_SD);
        if (dmem_ready) begin
          if (op_q == OP_LD) begin
            state_d = ST_WB;
          end else begin
            retire_c = 1'b1;
            state_d  = ST_FETCH;
          end
        end else if (expired_c) begin
          timeout_d = 1'b1;
          state_d   = ST_FETCH;
        end
      end

      ST_WB: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.mem_to_reg = (op_q == OP_LD);
        retire_c          = 1'b1;
        state_d           = ST_FETCH;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    cnt_d = cnt_q + INSTR_CNT_W'(retire_c);
  end

  assign imem_read   = ctrl_c.imem_read;
  assign ir_write    = ctrl_c.ir_write;
  assign pc_write    = ctrl_c.pc_write;
  assign pc_src      = ctrl_c.pc_src;
  assign ALUOp       = ctrl_c.alu_op;
  assign ALUSrc      = ctrl_c.alu_src;
  assign memRead     = ctrl_c.mem_read;
  assign memWrite    = ctrl_c.mem_write;
  assign memtoReg    = ctrl_c.mem_to_reg;
  assign regWrite    = ctrl_c.reg_write;
  assign instr_done  = retire_c;
  assign illegal_op  = illegal_q;
  assign mem_timeout = timeout_q;
  assign instr_count = cnt_q;

endmodule
